// File: rtl/oc8051_ecc_chk_if.sv
// rtl/oc8051_ecc_chk_if.sv - handshake and status bundle for the SECDED checker
interface oc8051_ecc_chk_if #(
  parameter int K     = 8,
  parameter int CNT_W = 8
);
  function automatic int calc_m(input int k);
    int mm;
    mm = 1;
    while ((1 << mm) < mm + k + 1) mm++;
    return mm;
  endfunction

  localparam int m = calc_m(K);
  localparam int n = m + K;

  logic [n:0]       q_i;
  logic             valid_i;
  logic             ready_o;
  logic [K-1:0]     d_o;
  logic             sec_o;
  logic             ded_o;
  logic             valid_o;
  logic             ready_i;
  logic             clr_i;
  logic [CNT_W-1:0] sec_cnt_o;
  logic [CNT_W-1:0] ded_cnt_o;
  logic             log_vld_o;
  logic [m-1:0]     log_syn_o;

  modport master (
    output q_i, valid_i, ready_i, clr_i,
    input  ready_o, d_o, sec_o, ded_o, valid_o, sec_cnt_o, ded_cnt_o, log_vld_o, log_syn_o
  );

  modport slave (
    input  q_i, valid_i, ready_i, clr_i,
    output ready_o, d_o, sec_o, ded_o, valid_o, sec_cnt_o, ded_cnt_o, log_vld_o, log_syn_o
  );
endinterface

// File: rtl/oc8051_ecc_chk.sv
// rtl/oc8051_ecc_chk.sv - two-stage SECDED check/correct stage with error counters
// and a sticky log of the first uncorrectable word's syndrome.
module oc8051_ecc_chk #(
  parameter int K      = 8,
  parameter int P0_LSB = 1,
  parameter int CNT_W  = 8
) (
  input logic              clk,
  input logic              rst,
  oc8051_ecc_chk_if.slave  bus
);
  function automatic int calc_m(input int k);
    int mm;
    mm = 1;
    while ((1 << mm) < mm + k + 1) mm++;
    return mm;
  endfunction

  localparam int m = calc_m(K);
  localparam int n = m + K;

  logic [n:1]       cw_in;
  logic [m-1:0]     syn_in;
  logic             ov_in;
  logic             en;

  logic             v1;
  logic [n:1]       cw1;
  logic [m-1:0]     syn1;
  logic             ov1;

  logic [n:1]       cw_fix;
  logic [K-1:0]     d_c;
  logic             sec_c;
  logic             ded_c;

  logic             v2;
  logic [K-1:0]     d2;
  logic             sec2;
  logic             ded2;
  logic [m-1:0]     syn2;
  logic [CNT_W-1:0] sec_cnt;
  logic [CNT_W-1:0] ded_cnt;
  logic             log_vld;
  logic [m-1:0]     log_syn;

  assign cw_in = (P0_LSB != 0) ? bus.q_i[n:1] : bus.q_i[n-1:0];
  assign ov_in = ^bus.q_i;
  assign en    = ~v2 | bus.ready_i;

  always_comb begin
    syn_in = '0;
    for (int i = 1; i <= n; i++)
      if (cw_in[i]) syn_in = syn_in ^ m'(i);
  end

  // A nonzero syndrome pointing past the codeword is treated as uncorrectable.
  always_comb begin
    int j;
    cw_fix = cw1;
    sec_c  = 1'b0;
    ded_c  = 1'b0;
    d_c    = '0;
    j      = 0;
    if (syn1 == '0) begin
      sec_c = ov1;
    end else if (!ov1 || int'(syn1) > n) begin
      ded_c = 1'b1;
    end else begin
      sec_c = 1'b1;
      for (int i = 1; i <= n; i++)
        if (m'(i) == syn1) cw_fix[i] = ~cw_fix[i];
    end
    for (int i = 1; i <= n; i++) begin
      if ((i & (i - 1)) != 0) begin
        d_c[j] = cw_fix[i];
        j++;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      cw1     <= '0;
      syn1    <= '0;
      ov1     <= 1'b0;
      v2      <= 1'b0;
      d2      <= '0;
      sec2    <= 1'b0;
      ded2    <= 1'b0;
      syn2    <= '0;
      sec_cnt <= '0;
      ded_cnt <= '0;
      log_vld <= 1'b0;
      log_syn <= '0;
    end else begin
      if (en) begin
        v1   <= bus.valid_i;
        cw1  <= cw_in;
        syn1 <= syn_in;
        ov1  <= ov_in;
        v2   <= v1;
        d2   <= d_c;
        sec2 <= v1 & sec_c;
        ded2 <= v1 & ded_c;
        syn2 <= syn1;
      end
      if (bus.clr_i) begin
        sec_cnt <= '0;
        ded_cnt <= '0;
        log_vld <= 1'b0;
        log_syn <= '0;
      end else if (v2 && bus.ready_i) begin
        if (sec2 && sec_cnt != '1) sec_cnt <= sec_cnt + CNT_W'(1);
        if (ded2 && ded_cnt != '1) ded_cnt <= ded_cnt + CNT_W'(1);
        if (ded2 && !log_vld) begin
          log_vld <= 1'b1;
          log_syn <= syn2;
        end
      end
    end
  end

  assign bus.ready_o   = en;
  assign bus.valid_o   = v2;
  assign bus.d_o       = d2;
  assign bus.sec_o     = sec2;
  assign bus.ded_o     = ded2;
  assign bus.sec_cnt_o = sec_cnt;
  assign bus.ded_cnt_o = ded_cnt;
  assign bus.log_vld_o = log_vld;
  assign bus.log_syn_o = log_syn;
endmodule

// File: tb/tb_oc8051_ecc_chk.sv
// tb/tb_oc8051_ecc_chk.sv - randomized self-checking bench for oc8051_ecc_chk
// against an encode/inject-error reference model.
module tb_oc8051_ecc_chk;
  typedef logic [12:0] cw_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vin = 1'b0;
  logic rdy = 1'b1;
  logic clr = 1'b0;
  cw_t  q   = '0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  oc8051_ecc_chk_if #(.K(8), .CNT_W(8)) bus8 ();
  oc8051_ecc_chk_if #(.K(8), .CNT_W(2)) bus2 ();

  assign bus8.q_i = q;  assign bus8.valid_i = vin;  assign bus8.ready_i = rdy;  assign bus8.clr_i = clr;
  assign bus2.q_i = q;  assign bus2.valid_i = vin;  assign bus2.ready_i = rdy;  assign bus2.clr_i = clr;

  oc8051_ecc_chk #(.K(8), .P0_LSB(1), .CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  oc8051_ecc_chk #(.K(8), .P0_LSB(1), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cw_t        wq[$];
  logic [7:0] exp_d[$];
  bit         exp_sec[$], exp_ded[$], exp_chk[$];
  int         exp_syn[$];
  logic [7:0] got_d[$];
  bit         got_sec[$], got_ded[$];
  int         es8 = 0, ed8 = 0, es2 = 0, ed2 = 0, elog_v = 0, elog_s = 0;

  always @(negedge clk)
    if (!rst && bus8.valid_o && rdy) begin
      got_d.push_back(bus8.d_o);
      got_sec.push_back(bus8.sec_o);
      got_ded.push_back(bus8.ded_o);
    end

  // Textbook extended Hamming encoder: parity bits make the position XOR zero, p0 makes overall parity even.
  function automatic cw_t enc(input logic [7:0] d);
    cw_t w;
    int  j, s;
    w = '0; j = 0; s = 0;
    for (int p = 1; p <= 12; p++)
      if ((p & (p - 1)) != 0) begin
        w[p] = d[j];
        if (d[j]) s = s ^ p;
        j++;
      end
    for (int b = 0; b < 4; b++) w[1 << b] = s[b];
    w[0] = ^w[12:1];
    return w;
  endfunction

  function automatic int sat(input int c, input bit inc, input int mx);
    return (inc && c < mx) ? c + 1 : c;
  endfunction

  task automatic clear_q();
    wq.delete(); exp_d.delete(); exp_sec.delete(); exp_ded.delete(); exp_chk.delete(); exp_syn.delete();
    got_d.delete(); got_sec.delete(); got_ded.delete();
  endtask

  task automatic gen(input logic [7:0] d, input int b1, input int b2);
    cw_t w;
    int  ne, syn;
    w = enc(d); ne = 0; syn = 0;
    if (b1 >= 0) begin w[b1] = ~w[b1]; ne++; syn = syn ^ b1; end
    if (b2 >= 0) begin w[b2] = ~w[b2]; ne++; syn = syn ^ b2; end
    wq.push_back(w); exp_d.push_back(d); exp_sec.push_back(ne == 1); exp_ded.push_back(ne == 2);
    exp_chk.push_back(ne < 2); exp_syn.push_back(syn);
  endtask

  task automatic model_counts();
    for (int i = 0; i < exp_d.size(); i++) begin
      es8 = sat(es8, exp_sec[i], 255); ed8 = sat(ed8, exp_ded[i], 255);
      es2 = sat(es2, exp_sec[i], 3);   ed2 = sat(ed2, exp_ded[i], 3);
      if (exp_ded[i] && elog_v == 0) begin elog_v = 1; elog_s = exp_syn[i]; end
    end
  endtask

  task automatic run(input int stall_len, input bit rand_rdy, input bit clr_on_xfer,
                     output int lat, output int stall_low, output int stall_bad);
    int idx, stall_rem, budget, acc_cyc, val_cyc;
    bit seen;
    idx = 0; stall_rem = stall_len; budget = 0; acc_cyc = -1; val_cyc = -1; seen = 0;
    lat = -1; stall_low = 0; stall_bad = 0;
    while ((idx < wq.size() || got_d.size() < wq.size()) && budget < 500) begin
      vin = (idx < wq.size());
      q   = vin ? wq[idx] : '0;
      if (bus8.valid_o) seen = 1;
      if (seen && stall_rem > 0) begin rdy = 1'b0; stall_rem--; end
      else rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      clr = clr_on_xfer && bus8.valid_o && rdy;
      @(negedge clk);
      if (bus8.valid_o && !rdy) begin
        if (bus8.ready_o === 1'b0) stall_low++; else stall_bad++;
      end
      if (vin && bus8.ready_o) begin if (acc_cyc < 0) acc_cyc = cyc; idx++; end
      if (bus8.valid_o && val_cyc < 0) val_cyc = cyc;
      @(posedge clk); #1; budget++;
    end
    vin = 1'b0; rdy = 1'b1; clr = 1'b0;
    if (acc_cyc >= 0 && val_cyc >= 0) lat = val_cyc - acc_cyc;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_chk++; if (bus8.valid_o !== 1'b0 || bus8.d_o !== 8'h00 || bus8.sec_o !== 1'b0 || bus8.ded_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: valid=%b d=%h sec=%b ded=%b, required 0/00/0/0", bus8.valid_o, bus8.d_o, bus8.sec_o, bus8.ded_o); end
    n_chk++; if (bus8.sec_cnt_o !== 8'd0 || bus8.ded_cnt_o !== 8'd0 || bus8.log_vld_o !== 1'b0 || bus8.log_syn_o !== 4'd0) begin
      n_fail++; $display("FAIL reset_status: sec_cnt=%0d ded_cnt=%0d log_vld=%b log_syn=%0d, required all 0", bus8.sec_cnt_o, bus8.ded_cnt_o, bus8.log_vld_o, bus8.log_syn_o); end
    n_chk++; if (bus8.ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: ready_o=%b, required 1", bus8.ready_o); end
  endtask

  task automatic test_clean();
    int lat, sl, sb;
    clear_q(); gen(8'h00, -1, -1); gen(8'hA5, -1, -1); gen(8'hFF, -1, -1);
    run(0, 0, 0, lat, sl, sb); model_counts();
    n_chk++; if (got_d.size() != 3) begin n_fail++; $display("FAIL clean_count: got %0d words, required 3", got_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      n_chk++; if (got_d[i] !== exp_d[i] || got_sec[i] !== 1'b0 || got_ded[i] !== 1'b0) begin
        n_fail++; $display("FAIL clean_word%0d: d=%h sec=%b ded=%b, required d=%h sec=0 ded=0", i, got_d[i], got_sec[i], got_ded[i], exp_d[i]); end
    end
    n_chk++; if (lat != 2) begin n_fail++; $display("FAIL clean_latency: %0d edges, required 2", lat); end
    n_chk++; if (bus8.sec_cnt_o !== 8'd0 || bus8.ded_cnt_o !== 8'd0) begin
      n_fail++; $display("FAIL clean_counters: sec=%0d ded=%0d, required 0/0", bus8.sec_cnt_o, bus8.ded_cnt_o); end
  endtask

  task automatic test_single_sweep();
    int lat, sl, sb;
    clear_q();
    for (int b = 0; b < 13; b++) gen(8'hA5, b, -1);
    run(0, 0, 0, lat, sl, sb); model_counts();
    n_chk++; if (got_d.size() != 13) begin n_fail++; $display("FAIL sweep_count: got %0d words, required 13", got_d.size()); end
    for (int i = 0; i < 13 && i < got_d.size(); i++) begin
      n_chk++; if (got_d[i] !== 8'hA5 || got_sec[i] !== 1'b1 || got_ded[i] !== 1'b0) begin
        n_fail++; $display("FAIL sweep_bit%0d: d=%h sec=%b ded=%b, required d=a5 sec=1 ded=0", i, got_d[i], got_sec[i], got_ded[i]); end
    end
    n_chk++; if (bus8.sec_cnt_o !== 8'd13) begin n_fail++; $display("FAIL sweep_sec_cnt: %0d, required 13", bus8.sec_cnt_o); end
  endtask

  task automatic test_double();
    int lat, sl, sb;
    clear_q(); gen(8'h3C, 1, 2);
    run(0, 0, 0, lat, sl, sb); model_counts();
    n_chk++; if (got_d.size() != 1 || got_ded[0] !== 1'b1 || got_sec[0] !== 1'b0) begin
      n_fail++; $display("FAIL double_flags: words=%0d, required one word with ded=1 sec=0", got_d.size()); end
    n_chk++; if (bus8.log_vld_o !== 1'b1 || bus8.log_syn_o !== 4'd3 || int'(bus8.log_syn_o) != elog_s) begin
      n_fail++; $display("FAIL double_log: vld=%b syn=%0d, required vld=1 syn=3", bus8.log_vld_o, bus8.log_syn_o); end
    clear_q(); gen(8'h5A, 4, 9);
    run(0, 0, 0, lat, sl, sb); model_counts();
    n_chk++; if (got_d.size() != 1 || got_ded[0] !== 1'b1) begin
      n_fail++; $display("FAIL double_second: words=%0d, required one ded word", got_d.size()); end
    n_chk++; if (bus8.log_syn_o !== 4'd3 || bus8.ded_cnt_o !== 8'(ed8)) begin
      n_fail++; $display("FAIL double_sticky: syn=%0d ded_cnt=%0d, required syn=3 ded_cnt=%0d", bus8.log_syn_o, bus8.ded_cnt_o, ed8); end
  endtask

  task automatic test_backpressure();
    int lat, sl, sb;
    clear_q();
    for (int i = 0; i < 4; i++) gen(8'($urandom), (i % 2 == 1) ? int'($urandom_range(0, 12)) : -1, -1);
    run(3, 0, 0, lat, sl, sb); model_counts();
    n_chk++; if (sl != 3 || sb != 0) begin
      n_fail++; $display("FAIL bp_ready: ready_o low %0d cycles, high %0d stalled cycles, required 3 and 0", sl, sb); end
    n_chk++; if (got_d.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d words, required 4", got_d.size()); end
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      n_chk++; if (got_d[i] !== exp_d[i] || got_sec[i] !== exp_sec[i] || got_ded[i] !== 1'b0) begin
        n_fail++; $display("FAIL bp_word%0d: d=%h sec=%b ded=%b, required d=%h sec=%b ded=0", i, got_d[i], got_sec[i], got_ded[i], exp_d[i], exp_sec[i]); end
    end
    n_chk++; if (bus8.sec_cnt_o !== 8'(es8) || bus8.ded_cnt_o !== 8'(ed8)) begin
      n_fail++; $display("FAIL bp_counters: sec=%0d ded=%0d, required %0d/%0d", bus8.sec_cnt_o, bus8.ded_cnt_o, es8, ed8); end
  endtask

  task automatic test_random();
    int lat, sl, sb, ne, b1;
    clear_q();
    for (int i = 0; i < 30; i++) begin
      ne = $urandom_range(0, 2); b1 = $urandom_range(0, 12);
      gen(8'($urandom), ne > 0 ? b1 : -1, ne > 1 ? (b1 + int'($urandom_range(1, 12))) % 13 : -1);
    end
    run(0, 1, 0, lat, sl, sb); model_counts();
    n_chk++; if (got_d.size() != 30) begin n_fail++; $display("FAIL rand_count: got %0d words, required 30", got_d.size()); end
    for (int i = 0; i < 30 && i < got_d.size(); i++) begin
      n_chk++; if (got_sec[i] !== exp_sec[i] || got_ded[i] !== exp_ded[i] || (exp_chk[i] && got_d[i] !== exp_d[i])) begin
        n_fail++; $display("FAIL rand_word%0d: d=%h sec=%b ded=%b, required d=%h sec=%b ded=%b", i, got_d[i], got_sec[i], got_ded[i], exp_d[i], exp_sec[i], exp_ded[i]); end
    end
    n_chk++; if (bus8.sec_cnt_o !== 8'(es8) || bus8.ded_cnt_o !== 8'(ed8) || bus8.log_syn_o !== 4'(elog_s)) begin
      n_fail++; $display("FAIL rand_status: sec=%0d ded=%0d syn=%0d, required %0d/%0d/%0d", bus8.sec_cnt_o, bus8.ded_cnt_o, bus8.log_syn_o, es8, ed8, elog_s); end
  endtask

  task automatic test_sat_clear();
    int lat, sl, sb;
    clr = 1'b1; @(posedge clk); #1 clr = 1'b0;
    es8 = 0; ed8 = 0; es2 = 0; ed2 = 0; elog_v = 0; elog_s = 0;
    n_chk++; if (bus8.sec_cnt_o !== 8'd0 || bus8.ded_cnt_o !== 8'd0 || bus8.log_vld_o !== 1'b0 || bus2.ded_cnt_o !== 2'd0) begin
      n_fail++; $display("FAIL clr_idle: sec=%0d ded=%0d log=%b, required all 0", bus8.sec_cnt_o, bus8.ded_cnt_o, bus8.log_vld_o); end
    clear_q();
    for (int i = 0; i < 5; i++) gen(8'($urandom), int'($urandom_range(0, 12)), -1);
    run(0, 0, 0, lat, sl, sb); model_counts();
    n_chk++; if (bus2.sec_cnt_o !== 2'd3 || int'(bus2.sec_cnt_o) != es2) begin
      n_fail++; $display("FAIL sat_cnt2: sec_cnt=%0d, required 3", bus2.sec_cnt_o); end
    n_chk++; if (bus8.sec_cnt_o !== 8'd5) begin n_fail++; $display("FAIL sat_cnt8: sec_cnt=%0d, required 5", bus8.sec_cnt_o); end
    clear_q(); gen(8'h77, 3, 6);
    run(0, 0, 1, lat, sl, sb);
    es8 = 0; ed8 = 0; es2 = 0; ed2 = 0; elog_v = 0; elog_s = 0;
    n_chk++; if (got_d.size() != 1 || got_ded[0] !== 1'b1) begin
      n_fail++; $display("FAIL clr_xfer_word: words=%0d, required one ded word", got_d.size()); end
    n_chk++; if (bus8.ded_cnt_o !== 8'd0 || bus2.ded_cnt_o !== 2'd0 || bus8.log_vld_o !== 1'b0 || bus2.log_vld_o !== 1'b0 || bus8.sec_cnt_o !== 8'd0) begin
      n_fail++; $display("FAIL clr_wins: ded8=%0d ded2=%0d log8=%b log2=%b sec8=%0d, required all 0", bus8.ded_cnt_o, bus2.ded_cnt_o, bus8.log_vld_o, bus2.log_vld_o, bus8.sec_cnt_o); end
  endtask

  task automatic test_reset_mid();
    int lat, sl, sb, ng;
    clear_q(); gen(8'h12, 5, -1); gen(8'h34, 0, 7);
    run(0, 0, 0, lat, sl, sb); model_counts();
    n_chk++; if (bus8.sec_cnt_o !== 8'd1 || bus8.ded_cnt_o !== 8'd1 || bus8.log_vld_o !== 1'b1) begin
      n_fail++; $display("FAIL rmid_pre: sec=%0d ded=%0d log=%b, required 1/1/1", bus8.sec_cnt_o, bus8.ded_cnt_o, bus8.log_vld_o); end
    ng = got_d.size();
    vin = 1'b1; q = enc(8'hC3); @(posedge clk); #1;
    q = enc(8'h3C); @(posedge clk); #1;
    vin = 1'b0; rdy = 1'b0;
    n_chk++; if (bus8.valid_o !== 1'b1) begin n_fail++; $display("FAIL rmid_inflight: valid_o=%b, required 1", bus8.valid_o); end
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0; rdy = 1'b1;
    n_chk++; if (bus8.valid_o !== 1'b0 || bus8.ready_o !== 1'b1) begin
      n_fail++; $display("FAIL rmid_pipe: valid_o=%b ready_o=%b, required 0/1", bus8.valid_o, bus8.ready_o); end
    n_chk++; if (bus8.sec_cnt_o !== 8'd0 || bus8.ded_cnt_o !== 8'd0 || bus8.log_vld_o !== 1'b0 || bus8.log_syn_o !== 4'd0) begin
      n_fail++; $display("FAIL rmid_status: sec=%0d ded=%0d log=%b syn=%0d, required all 0", bus8.sec_cnt_o, bus8.ded_cnt_o, bus8.log_vld_o, bus8.log_syn_o); end
    repeat (2) @(posedge clk); #1;
    n_chk++; if (bus8.valid_o !== 1'b0 || got_d.size() != ng) begin
      n_fail++; $display("FAIL rmid_drop: valid_o=%b extra words=%0d, required 0/0", bus8.valid_o, got_d.size() - ng); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_sweep();
    test_double();
    test_backpressure();
    test_random();
    test_sat_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/oc8051_ecc_chk.md
# oc8051_ecc_chk

Pipelined SECDED check/correct stage that consumes the extended-Hamming codewords produced by `oc8051_ecc_enc` (e.g. after storage in ECC-protected IRAM/XRAM) and returns corrected information bits. It sits directly downstream of the encoder/memory read port. It uses a valid/ready handshake, a two-stage register pipeline, saturating error counters and a sticky first-uncorrectable-error log for the debug/SFR interface.

## Interface
- `K`, 8, information vector size; must match the encoder.
- `P0_LSB`, 1, location of p0 in the codeword: 1 = bit 0, 0 = bit n; must match the encoder.
- `CNT_W`, 8, width of each error counter.
- `m`, calc(K), number of check bits; smallest m with 2^m >= m+K+1. Derived; do not override.
- `n`, m+K, codeword length excluding p0. Derived.
- `clk`, in, 1, single clock. All logic is on the rising edge.
- `rst`, in, 1, synchronous active-high reset.
- `q_i`, in, n+1, codeword in the encoder's `q_o` format.
- `valid_i`, in, 1, `q_i` is valid.
- `ready_o`, out, 1, the stage accepts `q_i` this cycle.
- `d_o`, out, K, corrected information bits.
- `sec_o`, out, 1, single error corrected for this word (includes a p0-only error).
- `ded_o`, out, 1, uncorrectable error for this word; `d_o` is uncorrected.
- `valid_o`, out, 1, output word valid.
- `ready_i`, in, 1, downstream accepts the output.
- `clr_i`, in, 1, clears the counters and the log.
- `sec_cnt_o`, out, CNT_W, saturating count of delivered sec words.
- `ded_cnt_o`, out, CNT_W, saturating count of delivered ded words.
- `log_vld_o`, out, 1, sticky flag: the first ded word has been captured.
- `log_syn_o`, out, m, syndrome of the first ded word.

## Operation
- **Codeword mapping**
  - Strip p0 as selected by `P0_LSB`; the remainder is `cw[n:1]`.
  - Parity bits are at power-of-2 positions. Data bits fill the non-power-of-2 positions in ascending order, so `d[0]` is at position 3.
- **Stage 1 (registered)**
  - Syndrome `s[m:1]` = XOR of the indices i (1..n) for which `cw[i]`=1.
  - Overall parity `ov` = XOR of all n+1 bits.
  - Register `cw`, `s`, `ov` and `v1`.
- **Stage 2 (registered) classification**
  - s=0, ov=0: clean.
  - s=0, ov=1: p0 error. Data is unchanged; sec=1.
  - s!=0, ov=1, s<=n: flip `cw[s]` and extract data; sec=1.
  - s!=0, ov=1, s>n: ded=1. This is an invalid position.
  - s!=0, ov=0: ded=1.
  - sec and ded are never both 1.
- **Handshake**
  - `en` = ~`valid_o` | `ready_i`, and `ready_o` = `en`.
  - When `en`=1, both stages advance: `v1`<=`valid_i`, `valid_o`<=`v1`.
  - When `en`=0, all pipeline registers hold. Bubbles are not compressed.
  - `d_o`, `sec_o` and `ded_o` are meaningful only while `valid_o`=1. When the stage 2 bubble is 0, `sec_o` and `ded_o` are forced to 0.
- **Counters**
  - Each counter increments on an output transfer (`valid_o` & `ready_i`) with the matching flag.
  - Counters saturate at 2^CNT_W-1.
- **Log**
  - On the first transfer with `ded_o`=1 while `log_vld_o`=0: set `log_vld_o` and capture the syndrome.
  - Later ded transfers leave the log unchanged.
- **`clr_i`**
  - Zeroes both counters and the log.
  - If a transfer happens in the same cycle, `clr_i` wins: the result is 0 and the event is not counted or logged.
  - `clr_i` does not affect the pipeline.

## Timing
- **Reset values:** `valid_o`=0, `v1`=0, `d_o`=0, `sec_o`=0, `ded_o`=0, both counters 0, `log_vld_o`=0, `log_syn_o`=0. `ready_o`=1 from the first cycle after reset.
- **Latency:** a word accepted at edge T is presented on `valid_o` after edge T+2 when no stall occurs. Throughput is 1 word/cycle.
- **Backpressure:** while `valid_o`=1 and `ready_i`=0, the outputs and `ready_o`=0 are stable. The upstream producer must hold `q_i` and `valid_i`.
- **Output changes:** counters and the log update on the edge after the transfer cycle. Outputs change only on `clk` edges.
- **Reset mid-operation:** `rst` drops in-flight words with no output transfer and clears the counters and log. `rst` takes priority over all other inputs.

## Test plan
- **Clean stream:** encode 0x00, 0xA5, 0xFF with `oc8051_ecc_enc`, with `ready_i`=1. Required: `d_o`=0x00/0xA5/0xFF on cycles T+2..T+4, sec=ded=0, counters 0.
- **Single-bit sweep:** encode 0xA5 and flip each of the 13 bits in turn, including p0. Required: `d_o`=0xA5 and `sec_o`=1 for every case; `sec_cnt_o`=13.
- **Double error:** encode 0x3C and flip `q` bits 1 and 2. Required: `ded_o`=1, `sec_o`=0. `log_vld_o`=1 and `log_syn_o` = XOR of the two corrupted codeword positions. A second ded word leaves `log_syn_o` unchanged.
- **Backpressure:** 4 back-to-back words with `ready_i` held 0 for 3 cycles after the first `valid_o`. Required: `ready_o`=0 during the stall, no word lost or duplicated, output order preserved, counts incremented once per word.
- **Saturation and clear:** with `CNT_W`=2, send 5 single-error words. Required: `sec_cnt_o`=3. Then assert `clr_i` in the same cycle as a ded transfer. Required: `ded_cnt_o`=0, `log_vld_o`=0.
- **Reset mid-stream:** assert `rst` with 2 words in flight. Required: `valid_o`=0 the next cycle, all counters and the log 0, `ready_o`=1.
